// File: rtl/rom_reader_pkg.sv
// Shared definitions for the ROM burst reader: FSM states, default sizes,
// and the FIFO occupancy-counter width helper.
package rom_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 4;
  localparam int DEF_LEN_W  = 8;
  localparam int DEF_DEPTH  = 4;

  // Counter must represent 0..depth inclusive.
  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int DEF_CNT_W = fifo_cnt_w(DEF_DEPTH);

endpackage

// File: rtl/rom_reader_fifo.sv
// Synchronous show-ahead FIFO holding {last, data} words for the burst reader.
module rom_reader_fifo
  import rom_reader_pkg::*;
#(
  parameter int WIDTH = DEF_DATA_W + 1,
  parameter int DEPTH = DEF_DEPTH,
  localparam int CNT_W = fifo_cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW-1:0]    head_idx;
  logic [CNT_W-1:0] count_q;
  logic             do_pop;

  assign do_pop = pop && (count_q != '0);

  // Storage, pointers and occupancy; storage is cleared so the head is never X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !do_pop)      count_q <= count_q + CNT_W'(1);
      else if (!push && do_pop) count_q <= count_q - CNT_W'(1);
    end
  end

  // When empty, show the most recently popped slot so the head holds its last value.
  always_comb begin
    head_idx = rd_ptr_q;
    if (count_q == '0) head_idx = rd_ptr_q - AW'(1);
  end

  assign head  = mem_q[head_idx];
  assign count = count_q;

endmodule

// File: rtl/rom_burst_reader.sv
// Burst read initiator: walks a ROM address range, absorbs the one-cycle read
// latency and re-emits the words as a valid/ready stream with a last flag.
module rom_burst_reader
  import rom_reader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  burst_len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  localparam int CNT_W = fifo_cnt_w(DEPTH);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  remaining_q;
  logic              rd_pending_q;
  logic              pend_last_q;
  logic              rd_issue;
  logic              load;
  logic              pop;
  logic [CNT_W-1:0]  fifo_count;
  logic [DATA_W:0]   fifo_head;

  assign pop = out_valid && out_ready;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic, read-issue rule and status outputs.
  always_comb begin
    state_d  = state_q;
    rd_issue = 1'b0;
    load     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (burst_len != '0) begin
            load    = 1'b1;
            state_d = ST_READ;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_READ: begin
        rd_issue = (remaining_q != '0) &&
                   ((int'(fifo_count) + int'(rd_pending_q)) <= (DEPTH - 2));
        if (rd_issue && remaining_q == LEN_W'(1)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Leave in the cycle the final word is accepted so done follows immediately.
        if (!rd_pending_q &&
            (fifo_count == '0 || (fifo_count == CNT_W'(1) && pop)))
          state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy = (state_q == ST_READ) || (state_q == ST_DRAIN);
    done = (state_q == ST_DONE);
  end

  // Address/remaining counters and the one-cycle read-latency tracker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q       <= '0;
      remaining_q  <= '0;
      rd_pending_q <= 1'b0;
      pend_last_q  <= 1'b0;
    end else begin
      if (load) begin
        addr_q      <= start_addr;
        remaining_q <= burst_len;
      end else if (rd_issue) begin
        addr_q      <= addr_q + ADDR_W'(1);
        remaining_q <= remaining_q - LEN_W'(1);
      end
      rd_pending_q <= rd_issue;
      pend_last_q  <= rd_issue && (remaining_q == LEN_W'(1));
    end
  end

  assign rom_addr = addr_q;

  rom_reader_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rd_pending_q),
    .push_data ({pend_last_q, rom_data}),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  assign out_valid = (fifo_count != '0);
  assign out_data  = fifo_head[DATA_W-1:0];
  assign out_last  = fifo_head[DATA_W];

endmodule

// File: tb/tb_rom_burst_reader.sv
// Randomized self-checking bench for rom_burst_reader with a ROM model and a
// queue-based expected-stream reference.
module tb_rom_burst_reader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] start_addr;
  logic [7:0] burst_len;
  logic       busy;
  logic       done;
  logic [7:0] rom_addr;
  logic [3:0] rom_data = 4'd0;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       out_last;

  logic [3:0] rom_tbl [256];

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [3:0] data;
    logic       last;
  } exp_t;

  rom_burst_reader #(
    .ADDR_W (8),
    .DATA_W (4),
    .LEN_W  (8),
    .DEPTH  (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .burst_len  (burst_len),
    .busy       (busy),
    .done       (done),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last)
  );

  always #5 clk = ~clk;

  // ROM with registered read data.
  always @(posedge clk) rom_data <= rom_tbl[rom_addr];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic fill_rom(input bit doubled);
    for (int a = 0; a < 256; a++)
      rom_tbl[a] = doubled ? 4'((a * 2) % 16) : 4'($urandom_range(0, 15));
  endtask

  // mode 0: always ready (exact timing checked); 1: random ready; 2: ready low in cycles 4..9.
  task automatic run_burst(input logic [7:0] sa, input logic [7:0] len, input int mode, input bit poke);
    exp_t exp_q[$];
    exp_t e;
    int   idx = 0;
    int   last_acc = -1;
    bit   seen_done = 1'b0;
    logic pv = 1'b0, pr = 1'b0, pl = 1'b0;
    logic [3:0] pd = 4'd0;
    for (int i = 0; i < int'(len); i++) begin
      e.data = rom_tbl[(int'(sa) + i) % 256];
      e.last = (i == int'(len) - 1);
      exp_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b1; start_addr = sa; burst_len = len; out_ready = 1'b1;
    for (int cyc = 1; cyc <= 400 && !seen_done; cyc++) begin
      @(negedge clk);
      start = poke && (cyc == 2);
      if (poke && cyc == 2) begin start_addr = 8'h55; burst_len = 8'd1; end
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = !(cyc >= 4 && cyc <= 9);
      endcase
      if (len == 0) begin
        check_val("empty_busy", busy, 0);
        check_val("empty_valid", out_valid, 0);
      end
      if (mode == 0 && cyc <= int'(len))
        check_val("rom_addr", rom_addr, (int'(sa) + cyc - 1) % 256);
      if (pv && !pr) begin
        check_val("hold_valid", out_valid, 1);
        check_val("hold_data", out_data, pd);
        check_val("hold_last", out_last, pl);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check_val("extra_word", 1, 0);
        else begin
          e = exp_q.pop_front();
          check_val("out_data", out_data, e.data);
          check_val("out_last", out_last, e.last);
          if (mode == 0) check_val("word_cycle", cyc, 3 + idx);
          idx++;
          last_acc = cyc;
        end
      end
      if (done) begin
        seen_done = 1'b1;
        check_val("done_words_left", exp_q.size(), 0);
        if (len == 0)       check_val("done_cycle_empty", cyc, 1);
        else if (mode == 0) check_val("done_cycle", cyc, int'(len) + 3);
        else                check_val("done_after_last", cyc, last_acc + 1);
      end
      pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
    end
    start = 1'b0;
    if (!seen_done) check_val("done_timeout", 0, 1);
    @(negedge clk);
    check_val("done_single", done, 0);
    check_val("idle_busy", busy, 0);
    check_val("idle_valid", out_valid, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; start_addr = 8'd0; burst_len = 8'd0; out_ready = 1'b0;
    fill_rom(1'b1);
    repeat (2) @(negedge clk);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_rom_addr", rom_addr, 0);
    check_val("rst_valid", out_valid, 0);
    check_val("rst_data", out_data, 0);
    check_val("rst_last", out_last, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full-speed burst over the 2*addr ROM.
    run_burst(8'h00, 8'd8, 0, 1'b0);
    // Empty burst.
    run_burst(8'h20, 8'd0, 0, 1'b0);
    // Backpressure window.
    fill_rom(1'b0);
    run_burst(8'h40, 8'd8, 2, 1'b0);
    // Address wrap.
    run_burst(8'hFE, 8'd4, 0, 1'b0);
    // Start pulsed during READ is ignored.
    run_burst(8'h30, 8'd6, 1, 1'b1);
    // Randomized bursts and ready patterns.
    for (int n = 0; n < 8; n++) begin
      fill_rom(1'b0);
      run_burst(8'($urandom_range(0, 255)), 8'($urandom_range(1, 14)), (n % 3 == 0) ? 0 : 1, 1'b0);
    end

    // Reset mid-burst: outputs clear asynchronously and no done follows.
    fill_rom(1'b0);
    @(negedge clk);
    start = 1'b1; start_addr = 8'h10; burst_len = 8'd20; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check_val("mid_busy_before_rst", busy, 1);
    #1 rst_n = 1'b0;
    #1;
    check_val("arst_busy", busy, 0);
    check_val("arst_done", done, 0);
    check_val("arst_rom_addr", rom_addr, 0);
    check_val("arst_valid", out_valid, 0);
    check_val("arst_data", out_data, 0);
    check_val("arst_last", out_last, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("arst_no_done", done, 0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("post_rst_no_done", done, 0);
      check_val("post_rst_valid", out_valid, 0);
    end
    run_burst(8'h77, 8'd3, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/rom_burst_reader.md
# rom_burst_reader

Burst read initiator for the lookup ROMs. On a `start` pulse it walks a contiguous range of addresses, drives the ROM address bus, and captures the ROM's registered read data. It re-emits the data as a valid/ready stream with a last-word flag. It sits between a control FSM and any consumer that needs table contents, and absorbs the ROM's one-cycle read latency and downstream backpressure.

## Interface
- `ADDR_W`, 8: ROM address width.
- `DATA_W`, 4: ROM data width.
- `LEN_W`, 8: burst length width, in words.
- `DEPTH`, 4: output FIFO depth. Must be ≥ 4 and a power of 2.

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  burst request. Sampled only in IDLE.
- `start_addr`  in  ADDR_W  first address of the burst, sampled with `start`.
- `burst_len`  in  LEN_W  number of words, sampled with `start`. 0 = empty burst.
- `busy`  out  1  high in READ and DRAIN.
- `done`  out  1  one-cycle pulse at burst completion.
- `rom_addr`  out  ADDR_W  registered ROM address.
- `rom_data`  in  DATA_W  ROM read data, valid one cycle after the address is presented.
- `out_valid`  out  1  stream data valid.
- `out_ready`  in  1  stream consumer ready.
- `out_data`  out  DATA_W  stream word.
- `out_last`  out  1  marks the final word of a burst. Qualified by `out_valid`.

## Operation
FSM states are IDLE, READ, DRAIN and DONE.

**IDLE**
- `start`=1 with `burst_len`≠0: load `rom_addr`←`start_addr` and remaining←`burst_len`, go to READ.
- `start`=1 with `burst_len`=0: go to DONE. No reads are issued.

**READ**
- Issue rule: `rd_issue` = (remaining≠0) && (fifo_count + rd_pending ≤ DEPTH−2).
  - `rd_pending` = 1 iff `rd_issue` was high in the previous cycle.
- On `rd_issue` in cycle k:
  - the address on `rom_addr` in cycle k is the requested read;
  - at the end of k, `rom_addr` increments and remaining decrements;
  - `rom_data` in cycle k+1 is written into the FIFO at the end of k+1.
- The FIFO entry is tagged `last` when it is the word issued with remaining=1.
- Go to DRAIN when remaining reaches 0.

**DRAIN**
- Stay until `rd_pending`=0 and the FIFO is empty, i.e. the last word has been accepted. Then go to DONE.

**DONE**
- `done`=1 for exactly one cycle, then return to IDLE.

**General rules**
- `rom_addr` increments modulo 2^ADDR_W and wraps from all-ones to 0 silently.
- `start` outside IDLE is ignored. A new burst can start in the cycle after DONE.
- The FIFO head drives `out_data` and `out_last`. `out_valid` = FIFO not empty. Pop on `out_valid && out_ready`.
- A FIFO write and a pop in the same cycle are both honoured, and the count is unchanged.
- The issue rule guarantees the FIFO never overflows. No write is ever dropped.
- `out_data` holds the last head value when `out_valid`=0. Its content is don't-care then, but it must not be X after reset.

## Timing
- **Reset values:**
  - outputs: `busy`=0, `done`=0, `rom_addr`=0, `out_valid`=0, `out_data`=0, `out_last`=0;
  - internal state: FSM in IDLE, FIFO empty, `rd_pending`=0.
- **Reset mid-burst:** state is cleared immediately and asynchronously. In-flight ROM data is discarded. There is no `done` pulse.
- **Latency:** `start` sampled at end of cycle 0 → `rom_addr`=`start_addr` in cycle 1 → first `out_valid` in cycle 3.
- **Throughput:** with `out_ready` held high, one word per cycle. An N-word burst has `out_last` in cycle N+2 and `done` in cycle N+3.
- **Empty burst:** `done` in cycle 1, and `busy` never rises.
- **Backpressure:**
  - `out_ready` low stalls issue within 2 cycles;
  - the FIFO holds at most DEPTH words;
  - the stream resumes on the first cycle `out_ready` is high, with no word lost or duplicated.
- **Output stability:** while `out_valid`=1 and `out_ready`=0, `out_data` and `out_last` are held stable.

## Structure
- Shared package `rom_reader_pkg` holds:
  - the FSM state encoding (IDLE, READ, DRAIN, DONE);
  - default widths and the default DEPTH;
  - the `$clog2`-based FIFO count width constant.
- Sub-module `rom_reader_fifo` is a synchronous FIFO of DEPTH × (DATA_W+1) bits, with the last flag stored alongside the data.
  - It provides a count output, simultaneous push/pop, and an async active-low reset.
- The top level contains the FSM, the address/remaining counters, the `rd_pending` flag and the issue rule.

## Test plan
- **Full-speed burst:** ROM model holds 2·addr. `start_addr`=0, `burst_len`=8, `out_ready`=1 → `out_data` = 0,2,4,…,14 in cycles 3–10; `out_last` in cycle 10; `done` in cycle 11.
- **Empty burst:** `burst_len`=0 → `done` in cycle 1, `busy` stays 0, no `out_valid`.
- **Backpressure:** burst of 8 with `out_ready` low for cycles 4–9, then high → no FIFO overflow, all 8 words delivered in order, data stable while stalled.
- **Address wrap:** `start_addr`=8'hFE, `burst_len`=4 → `rom_addr` sequence FE, FF, 00, 01. `out_last` on the 4th word.
- **Start while busy, then reset:** `start` pulsed during READ → ignored. `rst_n` low mid-burst → all outputs at reset values immediately, no `done`. A new burst of 3 words after reset completes correctly.
